// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: memory access sizes and LSU states
package cpu_types;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } memory_mask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  function automatic int mask_bytes(memory_mask_t m);
    case (m)
      MEM_BYTE:     return 1;
      MEM_HALFWORD: return 2;
      default:      return 4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane placement of store data and extraction/extension of load data
module lsu_lane_align
  import cpu_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  memory_mask_t              mask,
  input  logic                      second,
  input  logic                      sext,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           low,
  input  logic [XLEN-1:0]           high,
  output logic [XLEN/8-1:0]         byte_enable,
  output logic [XLEN-1:0]           lane_wdata,
  output logic [XLEN-1:0]           rdata
);
  localparam int NB = XLEN / 8;

  logic [2*NB-1:0]   size_bits;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wd_wide;
  logic [XLEN-1:0]   rd_shift;
  logic [$clog2(XLEN/8)+2:0] bit_off;

  assign bit_off = {off, 3'b000};

  // Shifting into a double-width field yields both bus beats at once:
  // the low half is the first beat, the high half is the spill-over beat.
  always_comb begin
    size_bits = '0;
    case (mask)
      MEM_BYTE:     size_bits[0]   = 1'b1;
      MEM_HALFWORD: size_bits[1:0] = 2'b11;
      default:      size_bits[3:0] = 4'hF;
    endcase
    be_wide     = size_bits << off;
    wd_wide     = {{XLEN{1'b0}}, wdata} << bit_off;
    byte_enable = second ? be_wide[2*NB-1:NB] : be_wide[NB-1:0];
    lane_wdata  = second ? wd_wide[2*XLEN-1:XLEN] : wd_wide[XLEN-1:0];
  end

  always_comb begin
    rd_shift = XLEN'({high, low} >> bit_off);
    case (mask)
      MEM_BYTE:     rdata = sext ? XLEN'(signed'(rd_shift[7:0]))  : XLEN'(rd_shift[7:0]);
      MEM_HALFWORD: rdata = sext ? XLEN'(signed'(rd_shift[15:0])) : XLEN'(rd_shift[15:0]);
      default:      rdata = sext ? XLEN'(signed'(rd_shift[31:0])) : XLEN'(rd_shift[31:0]);
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: request latch, bus sequencing FSM, response registers
module load_store_unit
  import cpu_types::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  memory_mask_t          req_mask,
  input  logic                  req_sext,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN/8-1:0]     mem_byte_enable,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t            state, state_next;
  logic                  we_q, sext_q, split_q, resp_err_q;
  memory_mask_t          mask_q;
  logic [ADDR_WIDTH-1:0] addr_q, base_addr;
  logic [XLEN-1:0]       wdata_q, low_q, resp_rdata_q;
  logic [OFF_W-1:0]      req_off;
  logic                  req_split, fault, finish, second;
  logic [NB-1:0]         lane_be;
  logic [XLEN-1:0]       lane_wdata, lane_rdata, low_in;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_split = (int'(req_off) + mask_bytes(req_mask)) > NB;
  assign fault     = req_split && (ALLOW_MISALIGNED == 0);
  assign base_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign second    = (state == SECOND);
  // The final beat's data goes straight into the result without waiting a cycle.
  assign low_in    = (state == FIRST) ? mem_rdata : low_q;
  assign finish    = mem_ready && (((state == FIRST) && !split_q) || (state == SECOND));

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .off         (addr_q[OFF_W-1:0]),
    .mask        (mask_q),
    .second      (second),
    .sext        (sext_q),
    .wdata       (wdata_q),
    .low         (low_in),
    .high        (mem_rdata),
    .byte_enable (lane_be),
    .lane_wdata  (lane_wdata),
    .rdata       (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      sext_q       <= 1'b0;
      split_q      <= 1'b0;
      mask_q       <= MEM_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      low_q        <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        sext_q  <= req_sext;
        split_q <= req_split;
        mask_q  <= req_mask;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (fault) begin
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
        end
      end
      if (state == FIRST && mem_ready) low_q <= mem_rdata;
      if (finish) begin
        resp_err_q   <= 1'b0;
        resp_rdata_q <= we_q ? '0 : lane_rdata;
      end
    end
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_valid       = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = fault ? RESP : FIRST;
      end
      FIRST, SECOND: begin
        mem_valid       = 1'b1;
        mem_we          = we_q;
        mem_addr        = second ? base_addr + ADDR_WIDTH'(NB) : base_addr;
        mem_byte_enable = lane_be;
        mem_wdata       = lane_wdata;
        if (mem_ready) state_next = ((state == FIRST) && split_q) ? SECOND : RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
